// File: rtl/setclr_pkg.sv
// setclr_pkg: shared types and constants for the set/clear pulse driver.
// The driver's optional feedback compare is enabled with SETCLR_CHECK_EN.
package setclr_pkg;

    // Default width of the per-command idle-gap field.
    localparam int GAP_W_DEFAULT = 4;

    // Command opcodes carried on cmd_op.
    localparam logic OP_SET = 1'b1;
    localparam logic OP_CLR = 1'b0;

    // Driver FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // True when the opcode asks for a set pulse.
    function automatic logic is_set_op(input logic op);
        return (op == OP_SET);
    endfunction

endpackage

// File: rtl/setclr_hold_cnt.sv
// setclr_hold_cnt: loadable down-counter that times the idle gap after a pulse.
// 'last' flags the final gap cycle so the FSM can return to IDLE on that edge.
module setclr_hold_cnt
    import setclr_pkg::*;
#(
    parameter int GAP_W = GAP_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [GAP_W-1:0] load_val,
    output logic             last
);

    logic [GAP_W-1:0] count;

    // Load on the pulse cycle, count down during the gap, never wrap below zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - GAP_W'(1);
        end
    end

    assign last = (count == GAP_W'(1));

endmodule

// File: rtl/setclr_driver.sv
// setclr_driver: turns set/clear commands into single registered pulses for
// the flipflop block, each followed by a programmable idle gap, and tracks
// the expected flop state. Define SETCLR_CHECK_EN to compare that expected
// state against the real flop output and raise a sticky 'mismatch'.
module setclr_driver
    import setclr_pkg::*;
#(
    parameter int GAP_W = GAP_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_op,
    input  logic [GAP_W-1:0] cmd_hold,
    output logic             set_o,
    output logic             clr_o,
    output logic             busy,
    output logic             shadow,
    input  logic             fb_in,
    output logic             mismatch
);

    state_t           state;
    logic             op_q;
    logic [GAP_W-1:0] hold_q;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_last;

    assign cnt_load = (state == PULSE);
    assign cnt_dec  = (state == HOLD);

    setclr_hold_cnt #(
        .GAP_W    (GAP_W)
    ) u_hold_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (hold_q),
        .last     (cnt_last)
    );

    // Command FSM; pulses, ready and busy are registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= OP_CLR;
            hold_q    <= '0;
            set_o     <= 1'b0;
            clr_o     <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            shadow    <= 1'b0;
        end else begin
            set_o <= 1'b0;
            clr_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q      <= cmd_op;
                        hold_q    <= cmd_hold;
                        state     <= PULSE;
                        set_o     <= is_set_op(cmd_op);
                        clr_o     <= !is_set_op(cmd_op);
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                PULSE: begin
                    shadow <= is_set_op(op_q);
                    if (hold_q == '0) begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (cnt_last) begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef SETCLR_CHECK_EN
    logic armed;
    logic sticky;
    logic live_err;

    // The compare is live in the same cycle so a wrong flop shows up at once;
    // shadow and the flop change on the same edge, so no cycle is masked.
    assign live_err = armed && (fb_in != shadow);
    assign mismatch = sticky | live_err;

    // Arm one cycle after reset release and latch any disagreement until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            armed  <= 1'b0;
            sticky <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (live_err) begin
                sticky <= 1'b1;
            end
        end
    end
`else
    logic unused_fb;

    assign unused_fb = fb_in;
    assign mismatch  = 1'b0;
`endif

endmodule
